// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock) feeding the
// seven-segment decoders; 4'hF is the minus glyph.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  input  logic                  signed_mode,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  negative,
  output logic                  overflow
);

  localparam int BW = 4 * DIGITS;
  localparam int SW = 4 * (DIGITS + 2);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] TOP_MASK = ~({BW{1'b1}} >> 4);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  mag_q, mag_d;
  logic [SW-1:0]     scratch_q, scratch_d;
  logic              neg_q, neg_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic              negative_q, negative_d;
  logic              overflow_q, overflow_d;

  logic [SW-1:0]     adj;
  logic              neg_in;
  logic [WIDTH-1:0]  mag_in;
  logic              extra_nz;
  logic              top_nz;
  logic              ovf;

  // Add-3 correction on every scratch digit, in parallel, before the shift.
  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < DIGITS + 2; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // -2^(WIDTH-1) negates to itself, which reads correctly as an unsigned magnitude.
  assign neg_in = signed_mode & bin_in[WIDTH-1];
  assign mag_in = neg_in ? (~bin_in + WIDTH'(1)) : bin_in;

  assign extra_nz = |scratch_q[SW-1 -: 8];
  assign top_nz   = |scratch_q[BW-1 -: 4];
  assign ovf      = extra_nz | (neg_q & top_nz);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mag_d      = mag_q;
    scratch_d  = scratch_q;
    neg_d      = neg_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    bcd_d      = bcd_q;
    negative_d = negative_q;
    overflow_d = overflow_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_SHIFT;
          cnt_d     = CW'(WIDTH);
          mag_d     = mag_in;
          neg_d     = neg_in;
          scratch_d = '0;
          busy_d    = 1'b1;
        end
      end
      S_SHIFT: begin
        scratch_d = {adj[SW-2:0], mag_q[WIDTH-1]};
        mag_d     = {mag_q[WIDTH-2:0], 1'b0};
        cnt_d     = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        state_d    = S_IDLE;
        busy_d     = 1'b0;
        done_d     = 1'b1;
        negative_d = neg_q;
        if (ovf) begin
          overflow_d = 1'b1;
          bcd_d      = '1;
        end else if (neg_q) begin
          overflow_d = 1'b0;
          bcd_d      = scratch_q[BW-1:0] | TOP_MASK;
        end else begin
          overflow_d = 1'b0;
          bcd_d      = scratch_q[BW-1:0];
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      mag_q      <= '0;
      scratch_q  <= '0;
      neg_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      negative_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mag_q      <= mag_d;
      scratch_q  <= scratch_d;
      neg_q      <= neg_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bcd_q      <= bcd_d;
      negative_q <= negative_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd_out  = bcd_q;
  assign negative = negative_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq with hand-computed expectations.
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [13:0] bin_in;
  logic        signed_mode;
  logic        busy;
  logic        done;
  logic [15:0] bcd_out;
  logic        negative;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  bin_to_bcd_seq #(.WIDTH(14), .DIGITS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .bin_in      (bin_in),
    .signed_mode (signed_mode),
    .busy        (busy),
    .done        (done),
    .bcd_out     (bcd_out),
    .negative    (negative),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at #1 after an edge with the DUT idle; returns #1 after the accepting edge.
  task automatic launch(input logic [13:0] b, input logic sm);
    start       = 1'b1;
    bin_in      = b;
    signed_mode = sm;
    @(posedge clk);
    #1;
    start       = 1'b0;
    bin_in      = ~b;
    signed_mode = ~sm;
  endtask

  // Counts edges after acceptance until done; optionally pokes start with 77 at edge +3.
  task automatic wait_done(input bit poke, output int n, output bit busy_ok);
    n       = 0;
    busy_ok = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      if (poke && i == 3) begin
        start  = 1'b1;
        bin_in = 14'd77;
      end
      @(posedge clk);
      #1;
      n = i;
      if (poke && i == 3) start = 1'b0;
      if (done) break;
      if (!busy) busy_ok = 1'b0;
    end
    if (!done) n = -1;
  endtask

  task automatic conv(input string tag, input logic [13:0] b, input logic sm, input bit poke,
                      input logic [15:0] exp_bcd, input logic exp_neg, input logic exp_ovf);
    int  n;
    bit  bok;
    launch(b, sm);
    chk({tag, ".busy_accept"}, 32'(busy), 32'd1);
    wait_done(poke, n, bok);
    chk({tag, ".latency"}, n, 32'd15);
    chk({tag, ".busy_held"}, 32'(bok), 32'd1);
    chk({tag, ".busy_at_done"}, 32'(busy), 32'd0);
    chk({tag, ".bcd"}, 32'(bcd_out), 32'(exp_bcd));
    chk({tag, ".neg"}, 32'(negative), 32'(exp_neg));
    chk({tag, ".ovf"}, 32'(overflow), 32'(exp_ovf));
  endtask

  initial begin
    int  n;
    int  done_seen;
    bit  bok;

    rst         = 1'b1;
    start       = 1'b0;
    bin_in      = '0;
    signed_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.bcd", 32'(bcd_out), 32'd0);
    chk("rst.neg", 32'(negative), 32'd0);
    chk("rst.ovf", 32'(overflow), 32'd0);

    conv("u1234",  14'd1234,  1'b0, 1'b0, 16'h1234, 1'b0, 1'b0);
    chk("u1234.done_pulse_cnt", 32'(done), 32'd1);
    @(posedge clk); #1;
    chk("u1234.done_clear", 32'(done), 32'd0);
    chk("u1234.hold", 32'(bcd_out), 32'h1234);

    conv("u9999",  14'd9999,  1'b0, 1'b0, 16'h9999, 1'b0, 1'b0);
    conv("u10000", 14'd10000, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b1);
    conv("u16383", 14'd16383, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b1);
    conv("u42",    14'd42,    1'b0, 1'b0, 16'h0042, 1'b0, 1'b0);
    conv("s-25",   14'h3FE7,  1'b1, 1'b0, 16'hF025, 1'b1, 1'b0);
    conv("s-999",  14'h3C19,  1'b1, 1'b0, 16'hF999, 1'b1, 1'b0);
    conv("s-1000", 14'h3C18,  1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b1);
    conv("s-8192", 14'h2000,  1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b1);
    conv("u8192",  14'h2000,  1'b0, 1'b0, 16'h8192, 1'b0, 1'b0);
    conv("s-1",    14'h3FFF,  1'b1, 1'b0, 16'hF001, 1'b1, 1'b0);
    conv("s0",     14'd0,     1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);

    // Start pulsed mid-conversion is ignored; start in the done cycle is taken.
    conv("ignore", 14'd1234,  1'b0, 1'b1, 16'h1234, 1'b0, 1'b0);
    conv("b2b",    14'd77,    1'b0, 1'b0, 16'h0077, 1'b0, 1'b0);

    conv("pre_abort", 14'h3C19, 1'b1, 1'b0, 16'hF999, 1'b1, 1'b0);
    launch(14'd1234, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.done", 32'(done), 32'd0);
    chk("abort.bcd", 32'(bcd_out), 32'd0);
    chk("abort.neg", 32'(negative), 32'd0);
    chk("abort.ovf", 32'(overflow), 32'd0);
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    chk("abort.no_done", done_seen, 32'd0);
    conv("u5", 14'd5, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0);

    // Touch otherwise-unused locals from the task outputs.
    wait_done(1'b0, n, bok);
    chk("idle.no_done", n, -32'sd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
